dk_sprite_renderer: RTL

DK_SPRITE_RENDERER -- requirements
Module: dk_sprite_renderer

---
 rtl/dk_sprite_pkg.sv | 29 ++
 rtl/dk_palette.sv | 33 +++
 rtl/dk_sprite_renderer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dk_sprite_pkg.sv
// Shared constants, palette colours and the renderer state type for the
// Donkey Kong sprite renderer.
package dk_sprite_pkg;

  localparam int SPR_W = 64;
  localparam int SPR_H = 32;
  localparam int H_VIS = 640;
  localparam int V_VIS = 480;

  localparam logic [23:0] PAL_FUR  = 24'h8B3A0E;
  localparam logic [23:0] PAL_SKIN = 24'hF0B070;
  localparam logic [23:0] PAL_EYE  = 24'hFFFFFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic [5:0] mirror_col(input logic [5:0] col, input logic facing);
    logic [5:0] res;
    if (facing) begin
      res = 6'(SPR_W - 1) - col;
    end else begin
      res = col;
    end
    return res;
  endfunction

endpackage

// File: rtl/dk_palette.sv
// Maps a 3-bit sprite palette index to 24-bit RGB and an opacity flag.
module dk_palette
  import dk_sprite_pkg::*;
(
  input  logic [2:0]  idx_i,
  output logic [23:0] rgb_o,
  output logic        opaque_o
);

  always_comb begin
    rgb_o    = 24'h000000;
    opaque_o = 1'b0;
    case (idx_i)
      3'd1: begin
        rgb_o    = PAL_FUR;
        opaque_o = 1'b1;
      end
      3'd2: begin
        rgb_o    = PAL_SKIN;
        opaque_o = 1'b1;
      end
      3'd3: begin
        rgb_o    = PAL_EYE;
        opaque_o = 1'b1;
      end
      default: begin
        rgb_o    = 24'h000000;
        opaque_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dk_sprite_renderer.sv
// Two-stage sprite renderer: stage 1 computes hit and sprite-memory address,
// stage 2 turns the returned palette index into a registered RGB pixel.
module dk_sprite_renderer
  import dk_sprite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        facing_left,
  input  logic        enable,
  output logic [9:0]  horz,
  output logic [9:0]  vert,
  input  logic [2:0]  draw_dk,
  output logic        pix_opaque,
  output logic [23:0] rgb
);

  state_e      state_q, state_d;
  logic [9:0]  sh_x_q, sh_x_d;
  logic [9:0]  sh_y_q, sh_y_d;
  logic        sh_f_q, sh_f_d;
  logic        sh_en_q, sh_en_d;
  logic        hit_q, hit_d;
  logic [5:0]  horz_q, horz_d;
  logic [4:0]  vert_q, vert_d;
  logic        pix_q, pix_d;
  logic [23:0] rgb_q, rgb_d;

  logic [10:0] dx_s, dy_s;
  logic        in_x_s, in_y_s;
  logic [23:0] pal_rgb_s;
  logic        pal_opaque_s;

  dk_palette u_palette (
    .idx_i    (draw_dk),
    .rgb_o    (pal_rgb_s),
    .opaque_o (pal_opaque_s)
  );

  // 11-bit differences: a pixel left of / above the sprite wraps to >= 1024 and never hits
  assign dx_s   = {1'b0, hcount} - {1'b0, sh_x_q};
  assign dy_s   = {1'b0, vcount} - {1'b0, sh_y_q};
  assign in_x_s = (dx_s < 11'(SPR_W));
  assign in_y_s = (dy_s < 11'(SPR_H));

  always_comb begin
    state_d = state_q;
    sh_x_d  = sh_x_q;
    sh_y_d  = sh_y_q;
    sh_f_d  = sh_f_q;
    sh_en_d = sh_en_q;
    hit_d   = 1'b0;
    horz_d  = 6'd0;
    vert_d  = 5'd0;
    pix_d   = 1'b0;
    rgb_d   = 24'h000000;

    if (state_q == ST_ACTIVE) begin
      hit_d = video_on & sh_en_q & in_x_s & in_y_s;
    end else begin
      hit_d = 1'b0;
    end

    if (hit_d) begin
      horz_d = mirror_col(dx_s[5:0], sh_f_q);
      vert_d = dy_s[4:0];
    end else begin
      horz_d = 6'd0;
      vert_d = 5'd0;
    end

    pix_d = hit_q & pal_opaque_s;
    if (pix_d) begin
      rgb_d = pal_rgb_s;
    end else begin
      rgb_d = 24'h000000;
    end

    // Stage 1 above used the old shadow values; new ones apply from the next cycle
    if (frame_start) begin
      state_d = ST_ACTIVE;
      sh_x_d  = pos_x;
      sh_y_d  = pos_y;
      sh_f_d  = facing_left;
      sh_en_d = enable;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_x_q  <= 10'd0;
      sh_y_q  <= 10'd0;
      sh_f_q  <= 1'b0;
      sh_en_q <= 1'b0;
      hit_q   <= 1'b0;
      horz_q  <= 6'd0;
      vert_q  <= 5'd0;
      pix_q   <= 1'b0;
      rgb_q   <= 24'h000000;
    end else begin
      state_q <= state_d;
      sh_x_q  <= sh_x_d;
      sh_y_q  <= sh_y_d;
      sh_f_q  <= sh_f_d;
      sh_en_q <= sh_en_d;
      hit_q   <= hit_d;
      horz_q  <= horz_d;
      vert_q  <= vert_d;
      pix_q   <= pix_d;
      rgb_q   <= rgb_d;
    end
  end

  assign horz       = {4'd0, horz_q};
  assign vert       = {5'd0, vert_q};
  assign pix_opaque = pix_q;
  assign rgb        = rgb_q;

endmodule
